// File: rtl/pc_deserializer_if.sv
// Handshake/stream bundle for pc_deserializer.
// The pperr signal exists only when PC_DESER_PARITY_EN is defined.
interface pc_deserializer_if #(
    parameter int unsigned WIDTH = 9
);
    logic             pp_0;
    logic             pstart;
    logic             pz;
    logic             pready;
    logic [WIDTH-1:0] pq;
    logic             pvalid;
    logic             pbusy;
    logic             povf;
`ifdef PC_DESER_PARITY_EN
    logic             pperr;

    modport master (
        output pp_0, pstart, pz, pready,
        input  pq, pvalid, pbusy, povf, pperr
    );

    modport slave (
        input  pp_0, pstart, pz, pready,
        output pq, pvalid, pbusy, povf, pperr
    );
`else
    modport master (
        output pp_0, pstart, pz, pready,
        input  pq, pvalid, pbusy, povf
    );

    modport slave (
        input  pp_0, pstart, pz, pready,
        output pq, pvalid, pbusy, povf
    );
`endif
endinterface

// File: rtl/pc_deserializer.sv
// Serial-to-parallel receiver, LSB first, with a one-entry valid/ready output buffer.
// Optional even-parity bit per frame enabled by defining PC_DESER_PARITY_EN.
module pc_deserializer #(
    parameter int unsigned WIDTH = 9
) (
    input logic              clock,
    input logic              preset_n,
    pc_deserializer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] done_word;
    logic             done;
    logic [WIDTH-1:0] pq_r;
    logic             pvalid_r;
    logic             pbusy_r;
    logic             povf_r;
    logic             last_bit;

`ifdef PC_DESER_PARITY_EN
    logic             par_acc;
    logic             pperr_r;
    assign bus.pperr = pperr_r;
`endif

    assign bus.pq     = pq_r;
    assign bus.pvalid = pvalid_r;
    assign bus.pbusy  = pbusy_r;
    assign bus.povf   = povf_r;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // A frame completes on the enabled, non-restart cycle that receives its final bit.
    always_comb begin
        shift_next      = shreg;
        shift_next[cnt] = bus.pz;
        done            = 1'b0;
        done_word       = shift_next;
`ifdef PC_DESER_PARITY_EN
        done_word = shreg;
        if (bus.pp_0 && !bus.pstart && state == PARITY)
            done = 1'b1;
`else
        if (bus.pp_0 && !bus.pstart && state == SHIFT && last_bit)
            done = 1'b1;
`endif
    end

    always_ff @(posedge clock or negedge preset_n) begin
        if (!preset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            pq_r     <= '0;
            pvalid_r <= 1'b0;
            pbusy_r  <= 1'b0;
            povf_r   <= 1'b0;
`ifdef PC_DESER_PARITY_EN
            par_acc  <= 1'b0;
            pperr_r  <= 1'b0;
`endif
        end else begin
            povf_r <= 1'b0;

            if (pvalid_r && bus.pready) begin
                pvalid_r <= 1'b0;
`ifdef PC_DESER_PARITY_EN
                pperr_r  <= 1'b0;
`endif
            end

            if (bus.pp_0) begin
                if (bus.pstart) begin
                    state   <= SHIFT;
                    shreg   <= WIDTH'(bus.pz);
                    cnt     <= CW'(1);
                    pbusy_r <= 1'b1;
`ifdef PC_DESER_PARITY_EN
                    par_acc <= bus.pz;
`endif
                end else begin
                    case (state)
                        SHIFT: begin
                            shreg <= shift_next;
`ifdef PC_DESER_PARITY_EN
                            par_acc <= par_acc ^ bus.pz;
`endif
                            if (last_bit) begin
                                cnt <= '0;
`ifdef PC_DESER_PARITY_EN
                                state <= PARITY;
`else
                                state   <= IDLE;
                                pbusy_r <= 1'b0;
`endif
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        PARITY: begin
                            state   <= IDLE;
                            pbusy_r <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end

            // Load overrides the consume-clear above when both happen in one cycle.
            if (done) begin
                if (!pvalid_r || bus.pready) begin
                    pq_r     <= done_word;
                    pvalid_r <= 1'b1;
`ifdef PC_DESER_PARITY_EN
                    pperr_r  <= par_acc ^ bus.pz;
`endif
                end else begin
                    povf_r <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_deserializer.sv
// Directed self-checking bench for pc_deserializer (WIDTH=9).
// Parity cases run only when PC_DESER_PARITY_EN is defined.
module tb_pc_deserializer;
    localparam int unsigned WIDTH = 9;

    logic clock    = 1'b0;
    logic preset_n = 1'b0;

    always #5 clock = ~clock;

    pc_deserializer_if #(.WIDTH(WIDTH)) bus ();

    pc_deserializer #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .preset_n (preset_n),
        .bus      (bus)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.pp_0   = 1'b0;
        bus.pstart = 1'b0;
        step();
    endtask

    task automatic send_bit(input logic s, input logic z);
        bus.pp_0   = 1'b1;
        bus.pstart = s;
        bus.pz     = z;
        step();
        bus.pp_0   = 1'b0;
        bus.pstart = 1'b0;
    endtask

    // Disabled cycle with pstart/pz garbage that must be ignored.
    task automatic gap();
        bus.pp_0   = 1'b0;
        bus.pstart = 1'b1;
        bus.pz     = ~bus.pz;
        step();
        bus.pstart = 1'b0;
    endtask

`ifdef PC_DESER_PARITY_EN
    task automatic send_parity(input logic [WIDTH-1:0] w, input logic flip);
        send_bit(1'b0, (^w) ^ flip);
    endtask
`endif

    task automatic send_frame(input logic [WIDTH-1:0] w);
        for (int i = 0; i < int'(WIDTH); i++)
            send_bit(i == 0, w[i]);
`ifdef PC_DESER_PARITY_EN
        send_parity(w, 1'b0);
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        bus.pp_0   = 1'b0;
        bus.pstart = 1'b0;
        bus.pz     = 1'b0;
        bus.pready = 1'b1;

        // Reset state
        #3;
        check("rst_pq", 32'(bus.pq), 32'h0);
        check("rst_pvalid", 32'(bus.pvalid), 32'h0);
        check("rst_pbusy", 32'(bus.pbusy), 32'h0);
        check("rst_povf", 32'(bus.povf), 32'h0);
`ifdef PC_DESER_PARITY_EN
        check("rst_pperr", 32'(bus.pperr), 32'h0);
`endif
        #10 preset_n = 1'b1;
        idle();

        // Frame 0x10D, contiguous, pready=1
        w = 9'h10D;
        for (int i = 0; i < 9; i++) begin
            send_bit(i == 0, w[i]);
            if (i < 8) begin
                check("t1_busy", 32'(bus.pbusy), 32'h1);
                check("t1_novalid", 32'(bus.pvalid), 32'h0);
            end
        end
`ifdef PC_DESER_PARITY_EN
        send_parity(w, 1'b0);
`endif
        check("t1_pvalid", 32'(bus.pvalid), 32'h1);
        check("t1_pq", 32'(bus.pq), 32'h10D);
        check("t1_busy_end", 32'(bus.pbusy), 32'h0);
        idle();
        check("t1_consumed", 32'(bus.pvalid), 32'h0);
        check("t1_pq_hold", 32'(bus.pq), 32'h10D);

        // Same frame with disabled cycles interleaved
        for (int i = 0; i < 9; i++) begin
            send_bit(i == 0, w[i]);
            if (i < 8) begin
                gap();
                check("t2_busy", 32'(bus.pbusy), 32'h1);
                check("t2_novalid", 32'(bus.pvalid), 32'h0);
            end
        end
`ifdef PC_DESER_PARITY_EN
        gap();
        send_parity(w, 1'b0);
`endif
        check("t2_pvalid", 32'(bus.pvalid), 32'h1);
        check("t2_pq", 32'(bus.pq), 32'h10D);
        idle();

        // Two frames with pready=0: second dropped
        bus.pready = 1'b0;
        send_frame(9'h0AA);
        check("t3_pvalid1", 32'(bus.pvalid), 32'h1);
        check("t3_pq1", 32'(bus.pq), 32'h0AA);
        check("t3_noovf1", 32'(bus.povf), 32'h0);
        send_frame(9'h155);
        check("t3_ovf", 32'(bus.povf), 32'h1);
        check("t3_pq_kept", 32'(bus.pq), 32'h0AA);
        check("t3_pvalid2", 32'(bus.pvalid), 32'h1);
        idle();
        check("t3_ovf_pulse", 32'(bus.povf), 32'h0);
        check("t3_pvalid_hold", 32'(bus.pvalid), 32'h1);
        bus.pready = 1'b1;
        idle();
        check("t3_drain", 32'(bus.pvalid), 32'h0);
        check("t3_pq_after", 32'(bus.pq), 32'h0AA);

        // Restart after 4 bits, then full frame 0x1FF
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        check("t4_busy", 32'(bus.pbusy), 32'h1);
        check("t4_novalid", 32'(bus.pvalid), 32'h0);
        send_frame(9'h1FF);
        check("t4_pq", 32'(bus.pq), 32'h1FF);
        check("t4_pvalid", 32'(bus.pvalid), 32'h1);
        check("t4_noovf", 32'(bus.povf), 32'h0);
        idle();
        check("t4_noovf2", 32'(bus.povf), 32'h0);

        // Async reset during bit 5 with a word pending
        bus.pready = 1'b0;
        send_frame(9'h0AA);
        w = 9'h1FF;
        for (int i = 0; i < 5; i++)
            send_bit(i == 0, w[i]);
        bus.pp_0 = 1'b1;
        bus.pz   = 1'b1;
        preset_n = 1'b0;
        #1;
        check("t5_pq", 32'(bus.pq), 32'h0);
        check("t5_pvalid", 32'(bus.pvalid), 32'h0);
        check("t5_pbusy", 32'(bus.pbusy), 32'h0);
        check("t5_povf", 32'(bus.povf), 32'h0);
        step();
        preset_n = 1'b1;
        bus.pp_0 = 1'b0;
        idle();
        check("t5_still_idle", 32'(bus.pbusy), 32'h0);
        check("t5_still_empty", 32'(bus.pvalid), 32'h0);
        bus.pready = 1'b1;
        send_frame(9'h003);
        check("t5_pq_new", 32'(bus.pq), 32'h003);
        check("t5_pvalid_new", 32'(bus.pvalid), 32'h1);
        idle();

`ifdef PC_DESER_PARITY_EN
        // Parity good, then bad, then clear on consumption
        w = 9'h007;
        for (int i = 0; i < 9; i++)
            send_bit(i == 0, w[i]);
        send_bit(1'b0, 1'b1);
        check("par_ok_pq", 32'(bus.pq), 32'h007);
        check("par_ok", 32'(bus.pperr), 32'h0);
        idle();
        for (int i = 0; i < 9; i++)
            send_bit(i == 0, w[i]);
        send_bit(1'b0, 1'b0);
        check("par_bad_valid", 32'(bus.pvalid), 32'h1);
        check("par_bad", 32'(bus.pperr), 32'h1);
        idle();
        check("par_clear", 32'(bus.pperr), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
